mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single memory/MMIO bus (m_cmd, m_addr, write_data, read_data) between two requesters.
- Requester 0 is the CPU load/store port; requester 1 is a secondary master (loader or DMA).
- Serialises one transaction at a time with round-robin priority and a req/ack handshake.
- Holds the bus for the RAM read latency and returns captured read data.
- Sits between the masters and the RAM, switch and LED decode logic; bus encoding is m_cmd 00 = none, 01 = read, 10 = write.

Parameters:
- AW, 9: address width.
- DW, 16: data width.
- READ_LAT, 1: extra cycles m_cmd/m_addr are held after the issue cycle before read_data is sampled. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 request; held with cmd0/addr0/wdata0 stable until ack0.
- cmd0  in  2  requester 0 command.
- addr0  in  AW  requester 0 address.
- wdata0  in  DW  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, cmd1, addr1, wdata1, ack1: same as requester 0, for requester 1.
- rdata  out  DW  captured read data; valid in the ack cycle, held until the next capture.
- grant  out  2  one-hot owner during ISSUE/WAIT/DONE; 00 in IDLE.
- m_cmd  out  2  bus command.
- m_addr  out  AW  bus address.
- write_data  out  DW  bus write data.
- read_data  in  DW  bus read data (tristate-resolved).

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE; m_cmd=00, m_addr=0, write_data=0.
  - ack0=ack1=0, grant=00, rdata=0.
  - priority pointer prio=0; latency counter=0.
- All outputs are registered. There is no combinational path from req/cmd/addr/read_data to any output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Bus idle: m_cmd=00.
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, requester prio wins.
  - On a win, latch sel, cmd, addr and wdata of the winner; set grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive m_cmd=latched cmd, m_addr=latched addr, write_data=latched wdata.
  - Write (10): RAM/LED write occurs at the end of this cycle; next state DONE.
  - Read (01): load counter=READ_LAT-1; next state WAIT.
  - Cmd 00 or 11: drive m_cmd=00 (no bus activity); next state DONE; rdata is set to 0 at the DONE edge.
- WAIT:
  - Keep m_cmd=01 and m_addr driven.
  - If counter≠0, decrement and stay in WAIT.
  - If counter=0, capture read_data into rdata at the clock edge; go to DONE.
- DONE (1 cycle):
  - m_cmd=00; ack[sel]=1 (the other ack stays 0).
  - rdata valid (previous value retained for writes).
  - Set prio to !sel; go to IDLE.
- Latency from the edge at which req is sampled in IDLE:
  - Write: ack 2 cycles later.
  - Read: ack 2+READ_LAT cycles later (3 for the default).
  - Every transaction is followed by at least one IDLE cycle (m_cmd=00).
- A req still high in the IDLE cycle after ack counts as a new request. Requesters must drop req in the ack cycle to avoid a repeat.
- Changes to req/cmd/addr/wdata after grant are ignored until DONE.
- A non-granted requester's req is never lost; it wins at the next IDLE when the other requester is idle or prio favours it.
- With both requesters held high continuously, grants alternate 0,1,0,1 and neither is starved.
- Address decode (RAM vs 0x100 LEDs vs 0x140 switches) is not done here; all addresses are treated identically.

Test Plan:
- Reset, then req0=1, cmd0=10, addr0=0x005, wdata0=0xABCD → m_cmd=10, m_addr=0x005, write_data=0xABCD for exactly one cycle; ack0 pulses 2 cycles after sampling; ack1=0 throughout; grant=01.
- req1 read, addr1=0x140, bench drives read_data=0x00FF while m_cmd=01 → m_cmd=01 for 2 cycles; ack1 pulses at cycle 3 with rdata=0x00FF; rdata holds 0x00FF afterwards.
- req0 and req1 both high from reset, both writes, held → grant sequence 01,10,01,10; ack order 0,1,0,1; one IDLE cycle between transactions.
- req0 cmd0=11 → no cycle with m_cmd≠00; ack0 after 2 cycles; rdata=0.
- Reset asserted mid-WAIT of a read → m_cmd=00, grant=00, ack=0 immediately (same cycle); after release with req1 and req0 pending, requester 0 is granted first (prio back to 0).
- READ_LAT=3 build, read of RAM address 0x010 preloaded with 0x1234 → m_cmd=01 held 4 cycles; ack at cycle 5 with rdata=0x1234.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Requester and bus bundle for mem_bus_arbiter.
// slave = arbiter view, master = requester/bus-model view.
interface mem_bus_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          req0;
    logic [1:0]    cmd0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          req1;
    logic [1:0]    cmd1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [1:0]    grant;
    logic [1:0]    m_cmd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    modport slave (
        input  req0, cmd0, addr0, wdata0,
        input  req1, cmd1, addr1, wdata1,
        input  read_data,
        output ack0, ack1, rdata, grant,
        output m_cmd, m_addr, write_data
    );

    modport master (
        output req0, cmd0, addr0, wdata0,
        output req1, cmd1, addr1, wdata1,
        output read_data,
        input  ack0, ack1, rdata, grant,
        input  m_cmd, m_addr, write_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the shared memory/MMIO bus.
// One transaction at a time; every output comes straight from a flop.
module mem_bus_arbiter #(
    parameter int AW       = 9,
    parameter int DW       = 16,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [2:0] LAT_INIT = 3'(READ_LAT - 1);

    state_t        state, state_n;
    logic          sel, sel_n;
    logic          prio, prio_n;
    logic [1:0]    lcmd, lcmd_n;
    logic [2:0]    cnt, cnt_n;
    logic          ack0_q, ack0_n;
    logic          ack1_q, ack1_n;
    logic [DW-1:0] rdata_q, rdata_n;
    logic [1:0]    grant_q, grant_n;
    logic [1:0]    m_cmd_q, m_cmd_n;
    logic [AW-1:0] m_addr_q, m_addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          win;
    logic          pick;

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rdata      = rdata_q;
    assign bus.grant      = grant_q;
    assign bus.m_cmd      = m_cmd_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.write_data = wdata_q;

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 1'b0;
            prio     <= 1'b0;
            lcmd     <= CMD_NONE;
            cnt      <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata_q  <= '0;
            grant_q  <= 2'b00;
            m_cmd_q  <= CMD_NONE;
            m_addr_q <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            prio     <= prio_n;
            lcmd     <= lcmd_n;
            cnt      <= cnt_n;
            ack0_q   <= ack0_n;
            ack1_q   <= ack1_n;
            rdata_q  <= rdata_n;
            grant_q  <= grant_n;
            m_cmd_q  <= m_cmd_n;
            m_addr_q <= m_addr_n;
            wdata_q  <= wdata_n;
        end
    end

    // Next state and next output values for the transaction sequencer.
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        prio_n   = prio;
        lcmd_n   = lcmd;
        cnt_n    = cnt;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        rdata_n  = rdata_q;
        grant_n  = grant_q;
        m_cmd_n  = CMD_NONE;
        m_addr_n = m_addr_q;
        wdata_n  = wdata_q;
        win      = bus.req0 | bus.req1;
        pick     = (bus.req0 && bus.req1) ? prio : bus.req1;

        unique case (state)
            IDLE: begin
                grant_n = 2'b00;
                if (win) begin
                    sel_n    = pick;
                    state_n  = ISSUE;
                    grant_n  = pick ? 2'b10 : 2'b01;
                    lcmd_n   = pick ? bus.cmd1 : bus.cmd0;
                    m_addr_n = pick ? bus.addr1 : bus.addr0;
                    wdata_n  = pick ? bus.wdata1 : bus.wdata0;
                    // Unused encodings never reach the bus.
                    if (lcmd_n == CMD_RD || lcmd_n == CMD_WR)
                        m_cmd_n = lcmd_n;
                end
            end
            ISSUE: begin
                if (lcmd == CMD_RD) begin
                    cnt_n   = LAT_INIT;
                    m_cmd_n = CMD_RD;
                    state_n = WAIT;
                end else begin
                    state_n = DONE;
                    ack0_n  = ~sel;
                    ack1_n  = sel;
                    if (lcmd != CMD_WR)
                        rdata_n = '0;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_n   = cnt - 3'd1;
                    m_cmd_n = CMD_RD;
                end else begin
                    rdata_n = bus.read_data;
                    state_n = DONE;
                    ack0_n  = ~sel;
                    ack1_n  = sel;
                end
            end
            DONE: begin
                prio_n  = ~sel;
                grant_n = 2'b00;
                state_n = IDLE;
            end
        endcase
    end
endmodule
